regdst_wb_sequencer: RTL



---
 rtl/regdst_wb_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regdst_wb_sequencer.sv
// rtl/regdst_wb_sequencer.sv - multicycle RegDst/RegWrite writeback sequencer
//
// Latches a writeback class plus rt/rd on start, then walks the register-file
// write port through one write (or two for POP), tolerating bank stalls up to
// MAX_STALL cycles per write before aborting with a sticky timeout.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   start               request from control FSM, only honoured in IDLE
//   wb_class            writeback class, sampled with start
//   in_rt, in_rd        instruction rt/rd fields, sampled with start
//   wb_stall            register bank not ready; holds the current write
//   RegDst              mux select: 000 rt, 001 rd, 010 r31, 011 r29, 100 r30
//   RegWrite            register-file write enable
//   wr_addr             resolved destination index matching RegDst
//   busy                high whenever not IDLE
//   done                one-cycle completion pulse
//   timeout             sticky stall-abort flag, cleared on next accepted start
module regdst_wb_sequencer #(
  parameter int MAX_STALL = 15,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] wb_class,
  input  logic [4:0] in_rt,
  input  logic [4:0] in_rd,
  input  logic       wb_stall,
  output logic [2:0] RegDst,
  output logic       RegWrite,
  output logic [4:0] wr_addr,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  localparam logic [2:0] CLS_NONE  = 3'd0;
  localparam logic [2:0] CLS_RTYPE = 3'd2;
  localparam logic [2:0] CLS_JAL   = 3'd3;
  localparam logic [2:0] CLS_PUSH  = 3'd4;
  localparam logic [2:0] CLS_POP   = 3'd5;
  localparam logic [2:0] CLS_EXC   = 3'd6;
  localparam logic [2:0] CLS_RSVD  = 3'd7;

  localparam logic [2:0] SEL_RT  = 3'b000;
  localparam logic [2:0] SEL_RD  = 3'b001;
  localparam logic [2:0] SEL_R31 = 3'b010;
  localparam logic [2:0] SEL_R29 = 3'b011;
  localparam logic [2:0] SEL_R30 = 3'b100;

  // The abort fires on the MAX_STALL-th consecutive stall cycle of a write,
  // i.e. when the counter is about to reach MAX_STALL.
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MAX_STALL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W1   = 2'd1,
    ST_W2   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [2:0]       cls_q;
  logic [4:0]       rt_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_abort;

  always_comb begin
    state_nx    = state;
    RegDst      = SEL_RT;
    wr_addr     = 5'd0;
    RegWrite    = 1'b0;
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    stall_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (wb_class == CLS_NONE || wb_class == CLS_RSVD) ? ST_DONE : ST_W1;
        end
      end
      ST_W1: begin
        case (cls_q)
          CLS_RTYPE: begin RegDst = SEL_RD;  wr_addr = rd_q;  end
          CLS_JAL:   begin RegDst = SEL_R31; wr_addr = 5'd31; end
          CLS_PUSH:  begin RegDst = SEL_R29; wr_addr = 5'd29; end
          CLS_EXC:   begin RegDst = SEL_R30; wr_addr = 5'd30; end
          default:   begin RegDst = SEL_RT;  wr_addr = rt_q;  end
        endcase
        if (!wb_stall) begin
          // r0 is hard-wired; the cycle is spent but the strobe is held off.
          RegWrite = (wr_addr != 5'd0);
          state_nx = (cls_q == CLS_POP) ? ST_W2 : ST_DONE;
        end else if (stall_cnt == STALL_LAST) begin
          stall_abort = 1'b1;
          state_nx    = ST_DONE;
        end
      end
      ST_W2: begin
        RegDst  = SEL_R29;
        wr_addr = 5'd29;
        if (!wb_stall) begin
          RegWrite = 1'b1;
          state_nx = ST_DONE;
        end else if (stall_cnt == STALL_LAST) begin
          stall_abort = 1'b1;
          state_nx    = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cls_q     <= 3'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nx;
      // Each write state gets its own stall budget.
      if (state_nx != state) begin
        stall_cnt <= '0;
      end else if ((state == ST_W1 || state == ST_W2) && wb_stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (state == ST_IDLE && start) begin
        cls_q   <= wb_class;
        rt_q    <= in_rt;
        rd_q    <= in_rd;
        timeout <= 1'b0;
      end else if (stall_abort) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
